// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock controller.
// Holds the controller state encoding, the per-digit width and a helper
// that sizes the packed code vector from the number of digits.
package lock_pkg;

    // Each keypad digit selects one of four buttons, so two bits per digit.
    localparam int DIGIT_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_OPEN,
        ST_PROGRAM,
        ST_LOCKOUT
    } lock_state_t;

    // Width of a packed code holding code_len digits.
    function automatic int code_w(input int code_len);
        return code_len * DIGIT_W;
    endfunction

endpackage

// File: rtl/lock_edge_pulse.sv
// Level-to-pulse converter for one keypad or program-request line.
// The pulse is high for exactly one cycle, in the cycle after the level is
// first sampled high following a sampled low. A held level gives no further
// pulses; one sampled low re-arms the detector.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset (detector returns to "low seen")
//   level - raw debounced level
//   pulse - one-cycle press pulse
module lock_edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    typedef enum logic [1:0] {
        EP_ARMED,
        EP_FIRE,
        EP_HELD
    } ep_state_t;

    ep_state_t state;
    ep_state_t state_n;

    // State register; reset leaves the detector armed as if a low was seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EP_ARMED;
        end else begin
            state <= state_n;
        end
    end

    // FIRE lasts one cycle; a low sampled while firing re-arms directly so a
    // quick tap-release-tap still yields two pulses.
    always_comb begin
        state_n = state;
        case (state)
            EP_ARMED: if (level) state_n = EP_FIRE;
            EP_FIRE:  state_n = level ? EP_HELD : EP_ARMED;
            EP_HELD:  if (!level) state_n = EP_ARMED;
            default:  state_n = EP_ARMED;
        endcase
    end

    assign pulse = (state == EP_FIRE);

endmodule

// File: rtl/lock_sequencer.sv
// Digital-lock controller: turns keypad levels into press pulses, collects a
// CODE_LEN-digit entry, compares it with the stored code and opens the door
// on a match. Counts consecutive failures and enforces a lockout window, and
// allows reprogramming the code while open.
// Ports:
//   clk         - clock, all state on rising edge
//   rst         - asynchronous active-high reset
//   btn[3:0]    - button levels, btn[k] high = digit k held
//   set_code    - program-request level (edge detected)
//   unlocked    - high while open
//   error       - one-cycle pulse on a failed or aborted attempt
//   locked_out  - high during the lockout window
//   programming - high while a new code is being entered
//   digit_cnt   - digits accepted in the current entry/programming pass
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int                          CODE_LEN     = 4,
    parameter logic [code_w(CODE_LEN)-1:0] DEFAULT_CODE = 8'hE4,
    parameter int                          MAX_FAIL     = 3,
    parameter int                          LOCKOUT_CYC  = 16,
    parameter int                          OPEN_CYC     = 8,
    parameter int                          ENTRY_TO     = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       set_code,
    output logic       unlocked,
    output logic       error,
    output logic       locked_out,
    output logic       programming,
    output logic [2:0] digit_cnt
);

    localparam int CW      = code_w(CODE_LEN);
    localparam int TMR_MAX = (OPEN_CYC > LOCKOUT_CYC)
                           ? ((OPEN_CYC > ENTRY_TO) ? OPEN_CYC : ENTRY_TO)
                           : ((LOCKOUT_CYC > ENTRY_TO) ? LOCKOUT_CYC : ENTRY_TO);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);

    localparam logic [2:0]        LAST_DIGIT = 3'(CODE_LEN - 1);
    localparam logic [TMR_W-1:0]  OPEN_LAST  = TMR_W'(OPEN_CYC - 1);
    localparam logic [TMR_W-1:0]  LOCK_LAST  = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [TMR_W-1:0]  ENTRY_LAST = TMR_W'(ENTRY_TO - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);

    lock_state_t       state, state_n;
    logic [CW-1:0]     code, code_n;
    logic [CW-1:0]     shadow, shadow_n;
    logic [2:0]        cnt_n;
    logic [FAIL_W-1:0] fail_cnt, fail_n, fail_inc;
    logic [TMR_W-1:0]  timer, timer_n;
    logic              mismatch, mismatch_n;
    logic              error_n;

    logic [3:0] btn_p;
    logic       set_p;
    logic       btn_any, btn_onehot, press, multi;
    logic [1:0] digit;
    logic       digit_ok;

    for (genvar k = 0; k < 4; k++) begin : g_btn
        lock_edge_pulse u_btn_ep (
            .clk   (clk),
            .rst   (rst),
            .level (btn[k]),
            .pulse (btn_p[k])
        );
    end

    lock_edge_pulse u_set_ep (
        .clk   (clk),
        .rst   (rst),
        .level (set_code),
        .pulse (set_p)
    );

    // A set_code pulse masks any button pulse arriving in the same cycle.
    assign btn_any    = |btn_p;
    assign btn_onehot = btn_any && ((btn_p & (btn_p - 4'd1)) == 4'd0);
    assign press      = btn_onehot && !set_p;
    assign multi      = btn_any && !btn_onehot && !set_p;
    assign fail_inc   = fail_cnt + 1'b1;

    always_comb begin
        digit = 2'd0;
        case (btn_p)
            4'b0010: digit = 2'd1;
            4'b0100: digit = 2'd2;
            4'b1000: digit = 2'd3;
            default: digit = 2'd0;
        endcase
    end

    // digit_cnt is 0 in IDLE, so the same compare serves the first digit.
    assign digit_ok = (digit == code[int'(digit_cnt)*DIGIT_W +: DIGIT_W]);

    // All controller state, including the registered error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            code      <= DEFAULT_CODE;
            shadow    <= DEFAULT_CODE;
            digit_cnt <= 3'd0;
            fail_cnt  <= '0;
            timer     <= '0;
            mismatch  <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            code      <= code_n;
            shadow    <= shadow_n;
            digit_cnt <= cnt_n;
            fail_cnt  <= fail_n;
            timer     <= timer_n;
            mismatch  <= mismatch_n;
            error     <= error_n;
        end
    end

    // Next-state logic. One shared timer serves the open window, the lockout
    // window and the inter-digit idle limit; it is cleared on every state
    // change and on every accepted press, so it never wraps.
    always_comb begin
        state_n    = state;
        code_n     = code;
        shadow_n   = shadow;
        cnt_n      = digit_cnt;
        fail_n     = fail_cnt;
        timer_n    = timer;
        mismatch_n = mismatch;
        error_n    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (press || multi) begin
                    mismatch_n = multi || !digit_ok;
                    cnt_n      = 3'd1;
                    timer_n    = '0;
                    state_n    = ST_ENTRY;
                end
            end

            ST_ENTRY: begin
                if (press || multi) begin
                    timer_n = '0;
                    if (digit_cnt == LAST_DIGIT) begin
                        cnt_n = 3'd0;
                        if (!(mismatch || multi || !digit_ok)) begin
                            fail_n  = '0;
                            state_n = ST_OPEN;
                        end else begin
                            error_n = 1'b1;
                            fail_n  = fail_inc;
                            state_n = (fail_inc == FAIL_LIMIT) ? ST_LOCKOUT : ST_IDLE;
                        end
                    end else begin
                        mismatch_n = mismatch || multi || !digit_ok;
                        cnt_n      = digit_cnt + 3'd1;
                    end
                end else if (timer == ENTRY_LAST) begin
                    cnt_n   = 3'd0;
                    timer_n = '0;
                    state_n = ST_IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end

            ST_OPEN: begin
                if (set_p) begin
                    cnt_n    = 3'd0;
                    timer_n  = '0;
                    shadow_n = code;
                    state_n  = ST_PROGRAM;
                end else if (timer == OPEN_LAST) begin
                    timer_n = '0;
                    state_n = ST_IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end

            ST_PROGRAM: begin
                if (multi || (!press && timer == ENTRY_LAST)) begin
                    error_n = 1'b1;
                    cnt_n   = 3'd0;
                    timer_n = '0;
                    state_n = ST_IDLE;
                end else if (press) begin
                    shadow_n[int'(digit_cnt)*DIGIT_W +: DIGIT_W] = digit;
                    timer_n = '0;
                    if (digit_cnt == LAST_DIGIT) begin
                        code_n  = shadow_n;
                        cnt_n   = 3'd0;
                        state_n = ST_IDLE;
                    end else begin
                        cnt_n = digit_cnt + 3'd1;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end

            ST_LOCKOUT: begin
                if (timer == LOCK_LAST) begin
                    fail_n  = '0;
                    timer_n = '0;
                    state_n = ST_IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end

            default: begin
                cnt_n   = 3'd0;
                timer_n = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    assign unlocked    = (state == ST_OPEN);
    assign locked_out  = (state == ST_LOCKOUT);
    assign programming = (state == ST_PROGRAM);

endmodule
